// File: rtl/blob_frame_tx_pkg.sv
// blob_frame_tx_pkg
//   Shared types for the blob frame transmitter and its output stage:
//   default blob word width, the {eop, data} FIFO entry, the transmitter
//   FSM state encoding and the read-credit helper.
package blob_frame_tx_pkg;

  localparam int BLOB_DIN_W = 16;

  typedef struct packed {
    logic                  eop;
    logic [BLOB_DIN_W-1:0] data;
  } blob_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tx_state_e;

  // A read may be issued only if every word already owed to the output FIFO
  // (stored + in flight from the RAM, minus the one leaving this cycle)
  // still leaves a free slot for it. pop never exceeds count, so no underflow.
  function automatic logic credit_ok(input logic [1:0] count,
                                     input logic       inflight,
                                     input logic       pop);
    logic [2:0] pending;
    pending = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    return (pending < 3'd2);
  endfunction

endpackage

// File: rtl/blob_frame_tx_skid_fifo.sv
// blob_skid_fifo
//   Two-entry output FIFO for layer output stages. slot0 is always the head,
//   so the head value is held stable after the last pop.
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears entries/count)
//   push          write push_entry (accepted when not full, or full with pop)
//   push_entry    entry to store
//   pop           remove the head (ignored when empty)
//   head          current head entry
//   count         number of stored entries, 0..2
module blob_skid_fifo
  import blob_frame_tx_pkg::*;
#(
  parameter type entry_t = blob_entry_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  entry_t     push_entry,
  input  logic       pop,
  output entry_t     head,
  output logic [1:0] count
);

  entry_t     slot0_r;
  entry_t     slot1_r;
  logic [1:0] count_r;
  logic       push_s;
  logic       pop_s;

  // Qualify requests against occupancy; push at full is legal only with a pop
  always_comb begin
    pop_s  = pop & (count_r != 2'd0);
    push_s = push & ((count_r != 2'd2) | pop_s);
  end

  // Entry storage and occupancy; a pop shifts slot1 forward into the head
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_r <= '0;
      slot1_r <= '0;
      count_r <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            slot0_r <= push_entry;
          end else begin
            slot1_r <= push_entry;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          if (count_r == 2'd2) begin
            slot0_r <= slot1_r;
          end else begin
            slot0_r <= slot0_r;
          end
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            slot0_r <= push_entry;
          end else begin
            slot0_r <= slot1_r;
            slot1_r <= push_entry;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign head  = slot0_r;
  assign count = count_r;

endmodule

// File: rtl/blob_frame_tx.sv
// blob_frame_tx
//   Frame buffer and transmitter at the head of the blob pipeline. The host
//   loads one frame into an internal RAM while idle; a start pulse streams
//   FRAME_LEN words out on the blob en/eop/data interface, eop on the last.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   host_wr_en/addr/data      host buffer write port (dropped while busy)
//   start                     one-cycle request to transmit the frame
//   busy                      frame in progress
//   done                      one-cycle pulse after the eop transfer
//   wr_err                    sticky flag: host write attempted while busy
//   blob_dout_en              word transferred this cycle
//   blob_dout_rdy             downstream ready
//   blob_dout_eop             last word of frame (only with blob_dout_en)
//   blob_dout                 word data (FIFO head)
module blob_frame_tx
  import blob_frame_tx_pkg::*;
#(
  parameter int DIN_W     = BLOB_DIN_W,
  parameter int ADDR_W    = 13,
  parameter int FRAME_LEN = 3072
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_wr_en,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DIN_W-1:0]  host_wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              wr_err,
  output logic              blob_dout_en,
  input  logic              blob_dout_rdy,
  output logic              blob_dout_eop,
  output logic [DIN_W-1:0]  blob_dout
);

  typedef struct packed {
    logic             eop;
    logic [DIN_W-1:0] data;
  } tx_entry_t;

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_IDX_C = (ADDR_W + 1)'(FRAME_LEN - 1);

  if (FRAME_LEN < 1 || FRAME_LEN > DEPTH) begin : g_frame_len_check
    $error("blob_frame_tx: FRAME_LEN must lie in 1..2**ADDR_W");
  end

  logic [DIN_W-1:0]  mem_r [DEPTH];
  tx_state_e         state_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [ADDR_W:0]   issued_r;
  logic              busy_r;
  logic              done_r;
  logic              wr_err_r;
  logic              rd_valid_r;
  logic              rd_eop_r;
  logic [DIN_W-1:0]  rd_data_r;
  logic              rd_en_s;
  logic              fifo_not_empty_s;
  logic              xfer_s;
  logic [1:0]        fifo_count_s;
  tx_entry_t         push_entry_s;
  tx_entry_t         head_s;

  // Handshake, credit-gated read issue and the FIFO push payload
  always_comb begin
    fifo_not_empty_s  = (fifo_count_s != 2'd0);
    xfer_s            = fifo_not_empty_s & blob_dout_rdy;
    push_entry_s.eop  = rd_eop_r;
    push_entry_s.data = rd_data_r;
    if (state_r == ST_RUN) begin
      rd_en_s = credit_ok(fifo_count_s, rd_valid_r, xfer_s);
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // Host write port; writes are only committed while idle
  always_ff @(posedge clk) begin
    if (host_wr_en && (state_r == ST_IDLE)) begin
      mem_r[host_wr_addr] <= host_wr_data;
    end
  end

  // RAM read port with one cycle of registered latency; contents survive reset
  always_ff @(posedge clk) begin
    if (rd_en_s) begin
      rd_data_r <= mem_r[rd_addr_r];
    end
  end

  // Read-return qualifiers: one read in flight at most, eop marks index FRAME_LEN-1
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_r <= 1'b0;
      rd_eop_r   <= 1'b0;
    end else begin
      rd_valid_r <= rd_en_s;
      rd_eop_r   <= rd_en_s & (issued_r == LAST_IDX_C);
    end
  end

  // Transmit FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      rd_addr_r <= '0;
      issued_r  <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      wr_err_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r   <= ST_RUN;
            busy_r    <= 1'b1;
            rd_addr_r <= '0;
            issued_r  <= '0;
            wr_err_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (host_wr_en) begin
            wr_err_r <= 1'b1;
          end
          if (rd_en_s) begin
            // rd_addr may wrap to 0 after the last read of a full-depth frame
            rd_addr_r <= rd_addr_r + 1'b1;
            issued_r  <= issued_r + 1'b1;
            if (issued_r == LAST_IDX_C) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (host_wr_en) begin
            wr_err_r <= 1'b1;
          end
          if (xfer_s && head_s.eop) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  blob_skid_fifo #(
    .entry_t(tx_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_valid_r),
    .push_entry(push_entry_s),
    .pop       (xfer_s),
    .head      (head_s),
    .count     (fifo_count_s)
  );

  assign busy          = busy_r;
  assign done          = done_r;
  assign wr_err        = wr_err_r;
  assign blob_dout_en  = xfer_s;
  assign blob_dout_eop = xfer_s & head_s.eop;
  assign blob_dout     = head_s.data;

endmodule

// File: tb/tb_blob_frame_tx.sv
// tb_blob_frame_tx
//   Scoreboard bench: stimulus pushes expected {eop, data, cycle} entries,
//   per-DUT monitors pop and compare on every blob_dout_en transfer.
//   dut_a: 8-word frame filling an 8-deep buffer; dut_b: 1-word frame.
module tb_blob_frame_tx;

  typedef struct {
    logic        eop;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_wr_en, a_start, a_busy, a_done, a_wr_err, a_en, a_rdy, a_eop;
  logic [2:0]  a_wr_addr;
  logic [15:0] a_wr_data, a_dout;
  logic        b_wr_en, b_start, b_busy, b_done, b_wr_err, b_en, b_rdy, b_eop;
  logic [1:0]  b_wr_addr;
  logic [15:0] b_wr_data, b_dout;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   xfer_a = 0, done_a_cnt = 0, done_a_cyc = -1;
  int   xfer_b = 0, done_b_cnt = 0, done_b_cyc = -1;
  exp_t qa[$];
  exp_t qb[$];
  logic [15:0] mem_m [8];

  blob_frame_tx #(.DIN_W(16), .ADDR_W(3), .FRAME_LEN(8)) dut_a (
    .clk(clk), .rst(rst), .host_wr_en(a_wr_en), .host_wr_addr(a_wr_addr),
    .host_wr_data(a_wr_data), .start(a_start), .busy(a_busy), .done(a_done),
    .wr_err(a_wr_err), .blob_dout_en(a_en), .blob_dout_rdy(a_rdy),
    .blob_dout_eop(a_eop), .blob_dout(a_dout)
  );

  blob_frame_tx #(.DIN_W(16), .ADDR_W(2), .FRAME_LEN(1)) dut_b (
    .clk(clk), .rst(rst), .host_wr_en(b_wr_en), .host_wr_addr(b_wr_addr),
    .host_wr_data(b_wr_data), .start(b_start), .busy(b_busy), .done(b_done),
    .wr_err(b_wr_err), .blob_dout_en(b_en), .blob_dout_rdy(b_rdy),
    .blob_dout_eop(b_eop), .blob_dout(b_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor for dut_a: pop-and-compare on each transfer
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!rst) begin
      if (a_en) begin
        xfer_a++;
        if (qa.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL a_unexpected_xfer: actual data=0x%0h eop=%0b, required no transfer (cycle %0d)",
                   a_dout, a_eop, cyc);
        end else begin
          e = qa.pop_front();
          check("a_data", a_dout, e.data);
          check("a_eop", a_eop, e.eop);
          if (e.cyc >= 0) check("a_xfer_cycle", cyc, e.cyc);
        end
      end else begin
        check("a_eop_without_en", a_eop, 0);
      end
      check("a_fifo_count_le2", 32'(dut_a.u_fifo.count > 2'd2), 0);
      if (a_done) begin
        done_a_cnt++;
        done_a_cyc = cyc;
      end
    end
  end

  // Monitor for dut_b
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!rst) begin
      if (b_en) begin
        xfer_b++;
        if (qb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_unexpected_xfer: actual data=0x%0h, required no transfer (cycle %0d)", b_dout, cyc);
        end else begin
          e = qb.pop_front();
          check("b_data", b_dout, e.data);
          check("b_eop", b_eop, e.eop);
          if (e.cyc >= 0) check("b_xfer_cycle", cyc, e.cyc);
        end
      end
      if (b_done) begin
        done_b_cnt++;
        done_b_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_neg(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic write_a(input logic [2:0] addr, input logic [15:0] data);
    a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data;
    tick();
    a_wr_en = 1'b0;
  endtask

  task automatic start_a(output int s);
    a_start = 1'b1; s = cyc;
    tick();
    a_start = 1'b0;
  endtask

  task automatic push_frame_a(input int base);
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.eop  = (i == 7);
      e.data = mem_m[i];
      e.cyc  = (base < 0) ? -1 : base + i;
      qa.push_back(e);
    end
  endtask

  task automatic wait_done(input bit sel_b, input int d0, input string nm);
    int k;
    k = 0;
    while (((sel_b ? done_b_cnt : done_a_cnt) == d0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check(nm, 32'(k < 300), 1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int s, d0, x0, r;
    rst = 1'b1;
    a_wr_en = 1'b0; a_wr_addr = 3'd0; a_wr_data = 16'h0000; a_start = 1'b0; a_rdy = 1'b1;
    b_wr_en = 1'b0; b_wr_addr = 2'd0; b_wr_data = 16'h0000; b_start = 1'b0; b_rdy = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_wr_err", a_wr_err, 0);
    check("rst_en", a_en, 0);
    check("rst_eop", a_eop, 0);
    check("rst_dout", a_dout, 16'h0000);
    check("rst_b_busy", b_busy, 0);
    tick();
    rst = 1'b0;

    // T1: word i = i, rdy high, exact latency
    for (int i = 0; i < 8; i++) begin
      mem_m[i] = 16'(i);
      write_a(3'(i), mem_m[i]);
    end
    a_start = 1'b1; s = cyc;
    push_frame_a(s + 3);
    @(negedge clk);
    check("t1_busy_at_start", a_busy, 0);
    tick();
    a_start = 1'b0;
    @(negedge clk);
    check("t1_busy_after_start", a_busy, 1);
    goto_neg(s + 10);
    check("t1_busy_eop_cycle", a_busy, 1);
    check("t1_no_done_eop_cycle", a_done, 0);
    @(negedge clk);
    check("t1_done_cycle", a_done, 1);
    check("t1_busy_falls", a_busy, 0);
    tick();
    check("t1_done_count", done_a_cnt, 1);
    check("t1_queue_empty", qa.size(), 0);

    // T2: new pattern, rdy toggling 1,0,0,1
    for (int i = 0; i < 8; i++) begin
      mem_m[i] = 16'hA5C3 ^ (16'(i) * 16'h1357);
      write_a(3'(i), mem_m[i]);
    end
    d0 = done_a_cnt; x0 = xfer_a;
    start_a(s);
    push_frame_a(-1);
    for (int k = 0; k < 300 && done_a_cnt == d0; k++) begin
      a_rdy = ((k % 4) == 0) || ((k % 4) == 3);
      tick();
    end
    a_rdy = 1'b1;
    check("t2_done_seen", done_a_cnt, d0 + 1);
    check("t2_xfer_count", xfer_a - x0, 8);
    check("t2_queue_empty", qa.size(), 0);

    // T3: rdy low for 20 cycles after start
    a_rdy = 1'b0;
    d0 = done_a_cnt; x0 = xfer_a;
    start_a(s);
    goto_neg(s + 10);
    check("t3_stall_en", a_en, 0);
    check("t3_stall_head", a_dout, mem_m[0]);
    check("t3_stall_eop", a_eop, 0);
    while (cyc < s + 21) tick();
    check("t3_no_xfer_while_stalled", xfer_a - x0, 0);
    a_rdy = 1'b1; r = cyc;
    push_frame_a(r);
    wait_done(1'b0, d0, "t3_done_timeout");
    check("t3_done_cycle", done_a_cyc, r + 8);

    // T4: host write while busy is dropped and flagged
    d0 = done_a_cnt;
    start_a(s);
    push_frame_a(s + 3);
    write_a(3'd3, 16'hDEAD);
    @(negedge clk);
    check("t4_wr_err_set", a_wr_err, 1);
    wait_done(1'b0, d0, "t4_done_timeout");
    check("t4_wr_err_sticky", a_wr_err, 1);

    // T5: reset at the 4th transfer, then a clean restart
    start_a(s);
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.eop = 1'b0; e.data = mem_m[i]; e.cyc = s + 3 + i;
      qa.push_back(e);
    end
    @(negedge clk);
    check("t5_wr_err_cleared", a_wr_err, 0);
    while (cyc < s + 6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_rst_busy", a_busy, 0);
    check("t5_rst_done", a_done, 0);
    check("t5_rst_en", a_en, 0);
    check("t5_rst_eop", a_eop, 0);
    check("t5_rst_dout", a_dout, 16'h0000);
    check("t5_three_words_seen", qa.size(), 0);
    d0 = done_a_cnt;
    repeat (20) tick();
    check("t5_no_done_after_abort", done_a_cnt, d0);
    start_a(s);
    push_frame_a(s + 3);
    wait_done(1'b0, d0, "t5_done_timeout");
    check("t5_restart_done_cycle", done_a_cyc, s + 11);

    // T6: start re-pulsed mid-frame is ignored
    d0 = done_a_cnt;
    start_a(s);
    push_frame_a(s + 3);
    while (cyc < s + 5) tick();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    wait_done(1'b0, d0, "t6_done_timeout");
    check("t6_done_cycle", done_a_cyc, s + 11);
    repeat (15) tick();
    check("t6_single_done", done_a_cnt, d0 + 1);
    check("t6_queue_empty", qa.size(), 0);

    // T7: single-word frame build
    b_wr_en = 1'b1; b_wr_addr = 2'd0; b_wr_data = 16'h5A3C;
    tick();
    b_wr_addr = 2'd1; b_wr_data = 16'hFFFF;
    tick();
    b_wr_en = 1'b0;
    b_start = 1'b1; s = cyc;
    tick();
    b_start = 1'b0;
    begin
      exp_t e;
      e.eop = 1'b1; e.data = 16'h5A3C; e.cyc = s + 3;
      qb.push_back(e);
    end
    wait_done(1'b1, 0, "t7_done_timeout");
    check("t7_done_cycle", done_b_cyc, s + 4);
    repeat (5) tick();
    check("t7_single_xfer", xfer_b, 1);
    check("t7_single_done", done_b_cnt, 1);
    check("t7_queue_empty", qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
